// File: rtl/raster_to_blocks.sv
// raster_to_blocks: reorders a raster Y/Cr/Cb pixel stream into framed 8x8 block beats
// using a ping-pong pair of 8-line banks (one fills while the other is read out).
module raster_to_blocks #(
  parameter int N = 2,
  parameter int X_RES = 1920
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*8-1:0] in_data_y,
  input  logic [N*8-1:0] in_data_cr,
  input  logic [N*8-1:0] in_data_cb,
  input  logic           in_sol,
  input  logic           in_sof,
  output logic           out_valid,
  output logic [N*8-1:0] out_data_y,
  output logic [N*8-1:0] out_data_cr,
  output logic [N*8-1:0] out_data_cb,
  output logic           out_sob,
  output logic           out_eob,
  output logic           out_sof,
  output logic           sync_err,
  output logic           overrun
);
  localparam int BPL = X_RES / N;
  localparam int GPB = 8 / N;
  localparam int KB = X_RES / 8;
  localparam int BW = BPL > 1 ? $clog2(BPL) : 1;
  localparam int GW = GPB > 1 ? $clog2(GPB) : 1;
  localparam int KW = KB > 1 ? $clog2(KB) : 1;
  localparam int AW = BW + 4;
  localparam int DW = N * 24;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q, wr_word;
  logic [N*8-1:0] rd_y, rd_cr, rd_cb;
  logic [AW-1:0] rd_addr;
  logic wbank, rbank, ractive, wait_sol, ext, sof_pend, v1, sob1, eob1, sof1;
  logic short_line, excess, wr, busy, line_end, band_end, start, rd_en, rd_last;
  logic [1:0] full, band_sof;
  logic [2:0] wline, l_eff, rrow;
  logic [BW-1:0] wbeat, b_eff;
  logic [KW-1:0] rblk;
  logic [GW-1:0] rgrp;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign wr_word[i*24+:24] = {in_data_y[i*8+:8], in_data_cr[i*8+:8], in_data_cb[i*8+:8]};
    assign rd_y[i*8+:8] = rd_q[i*24+16+:8];
    assign rd_cr[i*8+:8] = rd_q[i*24+8+:8];
    assign rd_cb[i*8+:8] = rd_q[i*24+:8];
  end

  // A beat arriving after a completed line without in_sol is excess and never stored.
  assign short_line = in_valid && in_sol && !in_sof && wbeat != '0;
  assign excess = in_valid && !in_sol && wait_sol;
  assign wr = in_valid && !excess;
  assign l_eff = (in_sof || short_line) ? 3'd0 : wline;
  assign b_eff = in_sol ? '0 : wbeat;
  assign busy = full[wbank] || (ractive && rbank == wbank);
  assign line_end = b_eff == BW'(BPL - 1);
  assign band_end = line_end && l_eff == 3'd7;

  // The first read is issued combinationally on the cycle after a bank fills.
  assign start = !ractive && full[rbank];
  assign rd_en = ractive || start;
  assign rd_last = rblk == KW'(KB - 1) && rrow == 3'd7 && rgrp == GW'(GPB - 1);
  assign rd_addr = {rbank, rrow, BW'(rblk * GPB + rgrp)};

  always_ff @(posedge clk) begin
    if (wr && !busy) mem[{wbank, l_eff, b_eff}] <= wr_word;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      wline <= '0;
      wbeat <= '0;
      wait_sol <= 1'b0;
      ext <= 1'b0;
      sof_pend <= 1'b0;
      full <= '0;
      band_sof <= '0;
      sync_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync_err <= short_line || (excess && !ext);
      overrun <= wr && busy;
      if (rd_en && rd_last) full[rbank] <= 1'b0;
      if (excess) ext <= 1'b1;
      if (wr) begin
        wline <= l_eff;
        wbeat <= b_eff + 1'b1;
        wait_sol <= 1'b0;
        if (in_sof) sof_pend <= 1'b1;
        if (line_end) begin
          wbeat <= '0;
          wait_sol <= 1'b1;
          ext <= 1'b0;
          wline <= l_eff + 3'd1;
          if (band_end) begin
            full[wbank] <= 1'b1;
            band_sof[wbank] <= sof_pend || in_sof;
            sof_pend <= 1'b0;
            wbank <= !wbank;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ractive <= 1'b0;
      rbank <= 1'b0;
      rblk <= '0;
      rrow <= '0;
      rgrp <= '0;
      v1 <= 1'b0;
      sob1 <= 1'b0;
      eob1 <= 1'b0;
      sof1 <= 1'b0;
      out_valid <= 1'b0;
      out_sob <= 1'b0;
      out_eob <= 1'b0;
      out_sof <= 1'b0;
      out_data_y <= '0;
      out_data_cr <= '0;
      out_data_cb <= '0;
    end else begin
      v1 <= rd_en;
      sob1 <= rd_en && rgrp == '0 && rrow == 3'd0;
      eob1 <= rd_en && rgrp == GW'(GPB - 1) && rrow == 3'd7;
      sof1 <= rd_en && rgrp == '0 && rrow == 3'd0 && rblk == '0 && band_sof[rbank];
      if (rd_en) begin
        ractive <= !rd_last;
        if (rd_last) rbank <= !rbank;
        rgrp <= rgrp == GW'(GPB - 1) ? '0 : rgrp + 1'b1;
        if (rgrp == GW'(GPB - 1)) rrow <= rrow + 3'd1;
        if (rgrp == GW'(GPB - 1) && rrow == 3'd7) rblk <= rd_last ? '0 : rblk + 1'b1;
      end
      out_valid <= v1;
      out_sob <= sob1;
      out_eob <= eob1;
      out_sof <= sof1;
      out_data_y <= v1 ? rd_y : '0;
      out_data_cr <= v1 ? rd_cr : '0;
      out_data_cb <= v1 ? rd_cb : '0;
    end
  end
endmodule

// File: tb/tb_raster_to_blocks.sv
// tb_raster_to_blocks: directed bands checked against an image-buffer model of the block reorder.
module tb_raster_to_blocks;
  localparam int N = 2;
  localparam int XR = 16;
  localparam int BPL = 8;
  logic clk = 0, rst = 1, in_valid = 0, in_sol = 0, in_sof = 0;
  logic [15:0] in_data_y = 0, in_data_cr = 0, in_data_cb = 0;
  logic out_valid, out_sob, out_eob, out_sof, sync_err, overrun;
  logic [15:0] out_data_y, out_data_cr, out_data_cb;
  int errors = 0, checks = 0, cyc = 0, se_cnt = 0, last_in_cyc = 0, se0 = 0, nsof = 0;
  logic exp_se = 0;
  logic [50:0] exp_q[$];
  logic [50:0] cap_d[$];
  int cap_c[$];
  logic [23:0] img [8][XR];
  int m_line = 0, m_beat = 0;
  bit m_wait = 0, m_ext = 0, m_pend = 0;

  raster_to_blocks #(.N(N), .X_RES(XR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data_y(in_data_y), .in_data_cr(in_data_cr), .in_data_cb(in_data_cb),
    .in_sol(in_sol), .in_sof(in_sof), .out_valid(out_valid),
    .out_data_y(out_data_y), .out_data_cr(out_data_cr), .out_data_cb(out_data_cb),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
    .sync_err(sync_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [23:0] pix(input int l, input int c, input int s);
    logic [7:0] y;
    y = 8'(l * 16 + c + s);
    return {y, y ^ 8'h5a, y + 8'h33};
  endfunction

  // Completed band: block by block, row by row, two pixels per beat.
  task automatic emit(input bit sof);
    for (int k = 0; k < XR / 8; k++)
      for (int r = 0; r < 8; r++)
        for (int g = 0; g < 8 / N; g++) begin
          logic [23:0] p0, p1;
          p0 = img[r][k*8+g*2];
          p1 = img[r][k*8+g*2+1];
          exp_q.push_back({p1[23:16], p0[23:16], p1[15:8], p0[15:8], p1[7:0], p0[7:0],
                           g == 0 && r == 0, g == 3 && r == 7, sof && k == 0 && g == 0 && r == 0});
        end
  endtask

  task automatic model(input bit sol, input bit sof, input logic [23:0] p0, input logic [23:0] p1);
    int l, b;
    if (!sol && m_wait) begin
      exp_se = !m_ext;
      m_ext = 1;
      return;
    end
    if (sof) m_pend = 1;
    exp_se = sol && !sof && m_beat != 0;
    l = (sof || exp_se) ? 0 : m_line;
    b = sol ? 0 : m_beat;
    img[l][b*2] = p0;
    img[l][b*2+1] = p1;
    if (b == BPL - 1) begin
      m_beat = 0;
      m_wait = 1;
      m_ext = 0;
      m_line = (l + 1) % 8;
      if (l == 7) begin
        emit(m_pend);
        m_pend = 0;
      end
    end else begin
      m_beat = b + 1;
      m_line = l;
      m_wait = 0;
    end
  endtask

  task automatic beat(input bit v, input bit sol, input bit sof, input int l, input int b, input int s);
    logic [23:0] p0, p1;
    @(negedge clk);
    p0 = pix(l, b * 2, s);
    p1 = pix(l, b * 2 + 1, s);
    in_valid = v;
    in_sol = v && sol;
    in_sof = v && sof;
    in_data_y = {p1[23:16], p0[23:16]};
    in_data_cr = {p1[15:8], p0[15:8]};
    in_data_cb = {p1[7:0], p0[7:0]};
    exp_se = 0;
    if (v) begin
      model(sol, sof, p0, p1);
      last_in_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 0, 0, 0);
  endtask

  task automatic line(input int l, input int nb, input bit sof, input int s, input int gap);
    for (int b = 0; b < nb; b++) beat(1, b == 0, sof && b == 0, l, b, s);
    idle(gap);
  endtask

  task automatic band(input bit sof, input int s, input int gap);
    for (int l = 0; l < 8; l++) line(l, BPL, sof && l == 0, s, gap);
  endtask

  always @(posedge clk) begin
    logic [50:0] got;
    #2;
    chk("sync_err", sync_err, exp_se);
    chk("overrun", overrun, 0);
    if (sync_err) se_cnt++;
    got = {out_data_y, out_data_cr, out_data_cb, out_sob, out_eob, out_sof};
    if (out_valid) begin
      cap_d.push_back(got);
      cap_c.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got %h expected none", got);
      end else chk("beat", got, exp_q.pop_front());
    end else chk("idle_framing", {out_sob, out_eob, out_sof}, 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("reset_state", {out_valid, out_sob, out_eob, out_sof, sync_err, overrun,
                        out_data_y, out_data_cr, out_data_cb}, 0);
    rst = 0;
    // 1: single frame band with blanking between lines
    cap_d.delete(); cap_c.delete();
    band(1, 0, 8);
    idle(80);
    chk("t1_count", cap_d.size(), 64);
    chk("t1_b0_y", cap_d[0][50:35], 16'h0100);
    chk("t1_b0_flags", cap_d[0][2:0], 3'b101);
    chk("t1_b28_y", cap_d[28][50:35], 16'h7170);
    chk("t1_b31_y", cap_d[31][50:35], 16'h7776);
    chk("t1_b31_flags", cap_d[31][2:0], 3'b010);
    chk("t1_b32_y", cap_d[32][50:35], 16'h0908);
    chk("t1_b32_flags", cap_d[32][2:0], 3'b100);
    chk("t1_latency", cap_c[0] - last_in_cyc, 2);
    // 2: two bands with in_valid held continuously
    cap_d.delete(); cap_c.delete();
    band(1, 8'h40, 0);
    band(0, 8'h90, 0);
    idle(150);
    chk("t2_count", cap_d.size(), 128);
    chk("t2_contiguous", cap_c[127] - cap_c[0], 127);
    nsof = 0;
    foreach (cap_d[i]) nsof += int'(cap_d[i][0]);
    chk("t2_sof_count", nsof, 1);
    chk("t2_sof_first", cap_d[0][0], 1);
    // 3: short line 3 then a fresh band
    cap_d.delete(); cap_c.delete();
    se0 = se_cnt;
    line(0, BPL, 1, 8'h20, 2);
    line(1, BPL, 0, 8'h20, 2);
    line(2, BPL, 0, 8'h20, 2);
    line(3, 5, 0, 8'h20, 0);
    band(0, 8'h30, 2);
    idle(80);
    chk("t3_sync_err_pulses", se_cnt - se0, 1);
    chk("t3_count", cap_d.size(), 64);
    // 4: long line of 10 beats on line 2
    cap_d.delete(); cap_c.delete();
    se0 = se_cnt;
    line(0, BPL, 1, 0, 2);
    line(1, BPL, 0, 0, 2);
    line(2, 10, 0, 0, 2);
    for (int l = 3; l < 8; l++) line(l, BPL, 0, 0, 2);
    idle(80);
    chk("t4_sync_err_pulses", se_cnt - se0, 1);
    chk("t4_count", cap_d.size(), 64);
    chk("t4_row2_head", cap_d[8][50:35], 16'h2120);
    chk("t4_row2_tail", cap_d[43][50:35], 16'h2f2e);
    // 5: in_sof on line 5 restarts the band
    cap_d.delete(); cap_c.delete();
    for (int l = 0; l < 5; l++) line(l, BPL, 0, 8'h60, 2);
    band(1, 8'h70, 2);
    idle(80);
    chk("t5_count", cap_d.size(), 64);
    chk("t5_sof", cap_d[0][2:0], 3'b101);
    // 6: reset during readout
    cap_d.delete(); cap_c.delete();
    band(1, 8'h05, 2);
    for (int i = 0; i < 200 && cap_d.size() < 20; i++) idle(1);
    chk("t6_reached_beat20", cap_d.size(), 20);
    @(negedge clk);
    rst = 1;
    in_valid = 0; in_sol = 0; in_sof = 0;
    exp_se = 0;
    exp_q.delete();
    m_line = 0; m_beat = 0; m_wait = 0; m_ext = 0; m_pend = 0;
    @(posedge clk);
    #1;
    chk("t6_rst_outputs", {out_valid, out_sob, out_eob, out_sof, sync_err, overrun,
                           out_data_y, out_data_cr, out_data_cb}, 0);
    @(negedge clk);
    rst = 0;
    idle(10);
    chk("t6_no_beats_after_rst", cap_d.size(), 21);
    cap_d.delete(); cap_c.delete();
    band(1, 8'h11, 2);
    idle(80);
    chk("t6_fresh_count", cap_d.size(), 64);
    chk("t6_fresh_sof", cap_d[0][2:0], 3'b101);
    chk("t6_fresh_b0_y", cap_d[0][50:35], 16'h1211);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
